seed_source: RTL and testbench

Parametrised seed generator for the RNG-2D datapath: supplies NCH independent WIDTH-bit seeds, one per generator channel (x/y by default), to the LFSR cores. Replaces the fixed constant-seed block with three selectable seeding modes (fixed pattern, user-loaded, entropy-harvested), a reseed request/acknowledge handshake and an all-zero lockup guard. Sits between the board inputs (switches/buttons, already synchronised) and the generator cores.

---
 rtl/seed_pkg.sv | 31 +++
 rtl/seed_source_if.sv | 29 ++
 rtl/seed_harvester.sv | 44 ++++
 rtl/seed_source.sv | 115 +++++++++++
 tb/tb_seed_source.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/seed_pkg.sv
// Shared types and helpers for the RNG-2D seed source: FSM states, mode codes
// and the per-channel fixed seed pattern.
package seed_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATHER  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [1:0] MODE_FIXED   = 2'd0;
  localparam logic [1:0] MODE_LOAD    = 2'd1;
  localparam logic [1:0] MODE_HARVEST = 2'd2;

  // Widest seed channel the pattern helper can rotate.
  localparam int MAX_W = 64;

  // Rotate the low w bits of base left by (c mod w); bits at and above w are zero.
  function automatic logic [MAX_W-1:0] rotl_pattern(input logic [MAX_W-1:0] base,
                                                    input int w, input int c);
    logic [MAX_W-1:0] r;
    int sh;
    r  = '0;
    sh = c % w;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[(i + sh) % w] = base[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/seed_source_if.sv
// Board-side and core-side signals of the seed source, grouped so the bench
// and the top can share one bundle.
interface seed_source_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 2
);
  localparam int LCH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [1:0]           mode;
  logic                 load_en;
  logic [LCH_W-1:0]     load_ch;
  logic [WIDTH-1:0]     load_data;
  logic                 entropy_in;
  logic                 reseed_req;
  logic                 seed_ack;
  logic                 seed_valid;
  logic                 busy;
  logic [NCH*WIDTH-1:0] seed;

  modport master (
    output mode, load_en, load_ch, load_data, entropy_in, reseed_req, seed_ack,
    input  seed_valid, busy, seed
  );

  modport slave (
    input  mode, load_en, load_ch, load_data, entropy_in, reseed_req, seed_ack,
    output seed_valid, busy, seed
  );
endinterface

// File: rtl/seed_harvester.sv
// Entropy harvester: free-running counter whitening the noisy input bit and a
// shift register that collects NBITS harvested bits, first bit ending at the MSB.
module seed_harvester #(
  parameter int WIDTH = 16,
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_entropy,
  output logic [NBITS-1:0] o_word_next,
  output logic             o_done
);
  localparam int BC_W = $clog2(NBITS + 1);

  logic [WIDTH-1:0] r_cnt;
  logic [NBITS-1:0] r_shift;
  logic [BC_W-1:0]  r_bitcnt;
  logic             w_bit;

  assign w_bit       = i_entropy ^ r_cnt[0];
  // Word including this cycle's bit, so the final shift can be captured directly.
  assign o_word_next = {r_shift[NBITS-2:0], w_bit};
  assign o_done      = i_shift && (r_bitcnt == BC_W'(NBITS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (i_clear) begin
        r_shift  <= '0;
        r_bitcnt <= '0;
      end else if (i_shift) begin
        r_shift  <= o_word_next;
        r_bitcnt <= r_bitcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seed_source.sv
// Seed source for the RNG-2D LFSR cores: fixed, user-loaded or harvested seeds
// per channel, presented through a reseed request / acknowledge handshake.
module seed_source
  import seed_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               NCH          = 2,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h5555
) (
  input logic          CLK500Hz,
  input logic          rstn,
  seed_source_if.slave bus
);
  localparam int NBITS = NCH * WIDTH;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_shadow [NCH];
  logic [WIDTH-1:0] w_fixed  [NCH];
  logic [NBITS-1:0] r_seed, w_seed_next;
  logic [NBITS-1:0] w_fixed_bus, w_shadow_bus, w_harv_bus, w_harv_word;
  logic             r_seed_valid, r_busy;
  logic             w_seed_load, w_harv_clear, w_harv_shift, w_harv_done;

  // Per-channel fixed pattern, and zero-guarded views of shadow and harvest data.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_fixed[c] = WIDTH'(rotl_pattern(MAX_W'(DEFAULT_SEED), WIDTH, c));
    assign w_fixed_bus[c*WIDTH +: WIDTH]  = w_fixed[c];
    assign w_shadow_bus[c*WIDTH +: WIDTH] = (r_shadow[c] == '0) ? w_fixed[c] : r_shadow[c];
    assign w_harv_bus[c*WIDTH +: WIDTH]   = (w_harv_word[c*WIDTH +: WIDTH] == '0) ?
                                            w_fixed[c] : w_harv_word[c*WIDTH +: WIDTH];
  end

  seed_harvester #(
    .WIDTH (WIDTH),
    .NBITS (NBITS)
  ) u_harvester (
    .i_clk       (CLK500Hz),
    .i_rst       (rstn),
    .i_clear     (w_harv_clear),
    .i_shift     (w_harv_shift),
    .i_entropy   (bus.entropy_in),
    .o_word_next (w_harv_word),
    .o_done      (w_harv_done)
  );

  always_comb begin
    w_state_next = r_state;
    w_seed_next  = r_seed;
    w_seed_load  = 1'b0;
    w_harv_clear = 1'b0;
    w_harv_shift = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.reseed_req) begin
          case (bus.mode)
            MODE_LOAD: begin
              w_seed_next  = w_shadow_bus;
              w_seed_load  = 1'b1;
              w_state_next = PRESENT;
            end
            MODE_HARVEST: begin
              w_harv_clear = 1'b1;
              w_state_next = GATHER;
            end
            default: begin
              w_seed_next  = w_fixed_bus;
              w_seed_load  = 1'b1;
              w_state_next = PRESENT;
            end
          endcase
        end
      end
      GATHER: begin
        w_harv_shift = 1'b1;
        if (w_harv_done) begin
          w_seed_next  = w_harv_bus;
          w_seed_load  = 1'b1;
          w_state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.seed_ack) w_state_next = IDLE;
      end
      default: w_state_next = PRESENT;
    endcase
  end

  always_ff @(posedge CLK500Hz) begin
    if (rstn) begin
      r_state      <= PRESENT;
      r_seed       <= w_fixed_bus;
      r_seed_valid <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_seed_valid <= (w_state_next == PRESENT);
      r_busy       <= (w_state_next == GATHER);
      if (w_seed_load) r_seed <= w_seed_next;
    end
  end

  // Shadow writes are accepted in every state; out-of-range channels are dropped.
  always_ff @(posedge CLK500Hz) begin
    if (rstn) begin
      for (int c = 0; c < NCH; c++) r_shadow[c] <= w_fixed[c];
    end else if (bus.load_en && (int'(bus.load_ch) < NCH)) begin
      r_shadow[bus.load_ch] <= bus.load_data;
    end
  end

  assign bus.seed       = r_seed;
  assign bus.seed_valid = r_seed_valid;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_seed_source.sv
// Directed bench for seed_source: cycle model of the default 2x16 instance plus
// literal checks, and a 3x4 instance for rotation and out-of-range load_ch.
module tb_seed_source;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seed_source_if #(.WIDTH(16), .NCH(2)) bus ();
  seed_source_if #(.WIDTH(4),  .NCH(3)) bus3 ();

  seed_source #(.WIDTH(16), .NCH(2), .DEFAULT_SEED(16'h5555)) dut (
    .CLK500Hz (clk),
    .rstn     (rst),
    .bus      (bus.slave)
  );

  seed_source #(.WIDTH(4), .NCH(3), .DEFAULT_SEED(4'h9)) dut3 (
    .CLK500Hz (clk),
    .rstn     (rst),
    .bus      (bus3.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc_n    = 0;
  bit started  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- model of the 2x16 instance ----------------
  localparam logic [31:0] FIXED = 32'hAAAA_5555;
  logic [31:0] m_seed;
  logic        m_valid;
  int          m_left;
  logic [15:0] m_cnt;
  logic [15:0] m_shadow [2];
  bit          m_bits [$];

  function automatic logic [31:0] guard2(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    if (w[15:0]  == 16'h0) r[15:0]  = FIXED[15:0];
    if (w[31:16] == 16'h0) r[31:16] = FIXED[31:16];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_seed = FIXED; m_valid = 1'b1; m_left = 0; m_cnt = '0;
      m_shadow[0] = FIXED[15:0]; m_shadow[1] = FIXED[31:16];
      m_bits.delete();
    end else begin
      bit hb;
      logic [31:0] wd;
      hb = bus.entropy_in ^ m_cnt[0];
      if (m_valid) begin
        if (bus.seed_ack) m_valid = 1'b0;
      end else if (m_left > 0) begin
        m_bits.push_back(hb);
        m_left--;
        if (m_left == 0) begin
          for (int i = 0; i < 32; i++) wd[31-i] = m_bits[i];
          m_seed  = guard2(wd);
          m_valid = 1'b1;
        end
      end else if (bus.reseed_req) begin
        if (bus.mode == 2'd1) begin
          m_seed = guard2({m_shadow[1], m_shadow[0]}); m_valid = 1'b1;
        end else if (bus.mode == 2'd2) begin
          m_bits.delete(); m_left = 32;
        end else begin
          m_seed = FIXED; m_valid = 1'b1;
        end
      end
      if (bus.load_en) m_shadow[bus.load_ch] = bus.load_data;
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model seed_valid", {63'd0, bus.seed_valid}, {63'd0, m_valid});
      chk("model busy", {63'd0, bus.busy}, {63'd0, (m_left > 0)});
      chk("model seed", {32'd0, bus.seed}, {32'd0, m_seed});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic reseed(input logic [1:0] m);
    bus.mode = m; bus.reseed_req = 1'b1;
    cyc();
    bus.reseed_req = 1'b0;
  endtask

  task automatic ack_it();
    bus.seed_ack = 1'b1;
    cyc();
    bus.seed_ack = 1'b0;
  endtask

  task automatic write_sh(input logic ch, input logic [15:0] d);
    bus.load_en = 1'b1; bus.load_ch = ch; bus.load_data = d;
    cyc();
    bus.load_en = 1'b0;
  endtask

  initial begin
    int nbusy;
    bus.mode = 2'd0; bus.load_en = 1'b0; bus.load_ch = '0; bus.load_data = '0;
    bus.entropy_in = 1'b0; bus.reseed_req = 1'b0; bus.seed_ack = 1'b0;
    bus3.mode = 2'd0; bus3.load_en = 1'b0; bus3.load_ch = '0; bus3.load_data = '0;
    bus3.entropy_in = 1'b0; bus3.reseed_req = 1'b0; bus3.seed_ack = 1'b0;

    // Reset: constant seeds available immediately.
    cyc(); cyc();
    rst = 1'b0; cyc_n = 0; started = 1'b1;
    chk("reset seed", {32'd0, bus.seed}, 64'hAAAA_5555);
    chk("reset valid", {63'd0, bus.seed_valid}, 64'd1);
    chk("reset busy", {63'd0, bus.busy}, 64'd0);
    chk("reset seed 3x4", {52'd0, bus3.seed}, 64'h639);

    // Harvest with entropy 0, request at cycle 10.
    ack_it();
    chk("ack drops valid", {63'd0, bus.seed_valid}, 64'd0);
    while (cyc_n < 10) cyc();
    reseed(2'd2);
    nbusy = 0;
    while (!bus.seed_valid && cyc_n < 60) begin
      if (bus.busy) nbusy++;
      cyc();
    end
    chk("harvest valid cycle", 64'(cyc_n), 64'd43);
    chk("harvest busy cycles", 64'(nbusy), 64'd32);
    chk("harvest alternating seed", {32'd0, bus.seed}, 64'hAAAA_AAAA);

    // Harvest with ch0 bits forced to zero; mode and ack toggled mid-gather.
    ack_it();
    reseed(2'd2);
    for (int i = 0; i < 32; i++) begin
      if (i < 8)       bus.entropy_in = 1'b1;
      else if (i < 16) bus.entropy_in = 1'b0;
      else             bus.entropy_in = cyc_n[0];
      bus.mode     = 2'd1;
      bus.seed_ack = (i == 3);
      cyc();
    end
    bus.entropy_in = 1'b0; bus.seed_ack = 1'b0;
    chk("guard harvest valid", {63'd0, bus.seed_valid}, 64'd1);
    chk("guard harvest seed", {32'd0, bus.seed}, 64'h55AA_5555);

    // Reset in the 15th gather cycle; a reseed during gather is ignored.
    ack_it();
    reseed(2'd2);
    for (int i = 0; i < 14; i++) begin
      bus.reseed_req = (i == 5);
      bus.mode       = 2'd0;
      cyc();
    end
    bus.reseed_req = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0; cyc_n = 0;
    chk("abort seed", {32'd0, bus.seed}, 64'hAAAA_5555);
    chk("abort valid", {63'd0, bus.seed_valid}, 64'd1);
    chk("abort busy", {63'd0, bus.busy}, 64'd0);

    // Reseed while presenting is ignored, even after a shadow write.
    write_sh(1'b0, 16'h1234);
    bus.mode = 2'd1; bus.reseed_req = 1'b1;
    cyc(); cyc();
    bus.reseed_req = 1'b0;
    chk("present req ignored", {32'd0, bus.seed}, 64'hAAAA_5555);

    // LOAD with ch1 zero falls back to the fixed pattern.
    ack_it();
    write_sh(1'b1, 16'h0000);
    reseed(2'd1);
    chk("load valid", {63'd0, bus.seed_valid}, 64'd1);
    chk("load zero guard", {32'd0, bus.seed}, 64'hAAAA_1234);

    // Write coincident with LOAD reseed: seed takes the old shadow value.
    ack_it();
    bus.load_en = 1'b1; bus.load_ch = 1'b0; bus.load_data = 16'hCAFE;
    reseed(2'd1);
    bus.load_en = 1'b0;
    chk("load pre-write", {32'd0, bus.seed}, 64'hAAAA_1234);
    ack_it();
    reseed(2'd1);
    chk("load post-write", {32'd0, bus.seed}, 64'hAAAA_CAFE);

    // Reserved mode behaves as FIXED.
    ack_it();
    reseed(2'd3);
    chk("mode3 seed", {32'd0, bus.seed}, 64'hAAAA_5555);
    chk("mode3 valid", {63'd0, bus.seed_valid}, 64'd1);

    // 3x4 instance: channel 3 does not exist, so that write is dropped.
    bus3.seed_ack = 1'b1; cyc(); bus3.seed_ack = 1'b0;
    chk("3x4 idle", {63'd0, bus3.seed_valid}, 64'd0);
    bus3.load_en = 1'b1;
    bus3.load_ch = 2'd0; bus3.load_data = 4'hA; cyc();
    bus3.load_ch = 2'd1; bus3.load_data = 4'h0; cyc();
    bus3.load_ch = 2'd2; bus3.load_data = 4'h5; cyc();
    bus3.load_ch = 2'd3; bus3.load_data = 4'hF; cyc();
    bus3.load_en = 1'b0;
    bus3.mode = 2'd1; bus3.reseed_req = 1'b1; cyc(); bus3.reseed_req = 1'b0;
    chk("3x4 load seed", {52'd0, bus3.seed}, 64'h53A);
    chk("3x4 load valid", {63'd0, bus3.seed_valid}, 64'd1);

    cyc();
    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
